// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: IR/flags/memory handshake in, select/enable lines out.
// master = control unit, slave = datapath side.
interface mc_control_unit_if;
  logic [31:0] instr;
  logic        zero;
  logic        lt;
  logic        ltu;
  logic        mem_ready;
  logic        mem_req;
  logic        pc_write;
  logic        ir_write;
  logic        mem_write;
  logic        reg_write;
  logic        adr_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  result_src;
  logic [2:0]  imm_src;
  logic        illegal;
  logic [3:0]  state;

  modport master (
    input  instr, zero, lt, ltu, mem_ready,
    output mem_req, pc_write, ir_write, mem_write, reg_write, adr_src,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal, state
  );

  modport slave (
    output instr, zero, lt, ltu, mem_ready,
    input  mem_req, pc_write, ir_write, mem_write, reg_write, adr_src,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal, state
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control FSM: sequences the shared-ALU datapath and raises a sticky
// illegal-opcode trap. State encoding follows the listed order (FETCH=0 .. TRAP=14).
module mc_control_unit #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit ENABLE_JALR     = 1'b1,
  parameter bit ENABLE_UPPER    = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  mc_control_unit_if.master  bus
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
    StAluWb, StBranch, StJal, StJalr, StLink, StUpper, StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  state_e     state_q, state_d, illegal_next;
  logic       illegal_q;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       ready, taken;
  logic       mem_req, pc_write, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;

  assign op           = bus.instr[6:0];
  assign funct3       = bus.instr[14:12];
  assign ready        = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign illegal_next = TRAP_ON_ILLEGAL ? StTrap : StFetch;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = ~bus.zero;
      3'b100:  taken = bus.lt;
      3'b101:  taken = ~bus.lt;
      3'b110:  taken = bus.ltu;
      3'b111:  taken = ~bus.ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OpStore:        imm_src = 3'b001;
      OpBranch:       imm_src = 3'b010;
      OpJal:          imm_src = 3'b011;
      OpLui, OpAuipc: imm_src = 3'b100;
      default:        imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpReg:           state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = ENABLE_JALR ? StJalr : illegal_next;
          OpLui, OpAuipc:  state_d = ENABLE_UPPER ? StUpper : illegal_next;
          default:         state_d = illegal_next;
        endcase
      end
      StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
      StMemRead:  if (ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (ready) state_d = StFetch;
      StExecR, StExecI, StJal, StLink, StUpper: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJalr:     state_d = StLink;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) illegal_q <= 1'b1;
    end
  end

  // Moore decode from state_q; only FETCH (ready) and BRANCH (flags) look at live inputs.
  always_comb begin
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = ready;
        ir_write   = ready;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      StAluWb:  reg_write = 1'b1;
      StBranch: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = taken;
      end
      StJal: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      StJalr: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      StLink: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      StUpper: begin
        alu_src_a = op[5] ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
      end
      default: ;
    endcase
    // No write may issue in a reset cycle, even mid-instruction.
    if (reset) begin
      mem_req   = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.adr_src    = adr_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.result_src = result_src;
  assign bus.imm_src    = imm_src;
  assign bus.illegal    = illegal_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a default-parameter instance and a stripped-down one
// (no handshake, no JALR/upper, illegal opcodes skipped), checked cycle by cycle.
module tb_mc_control_unit;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3;
  localparam logic [3:0] MEMWB = 4'd4, MEMWRITE = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7;
  localparam logic [3:0] ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11;
  localparam logic [3:0] LINK = 4'd12, UPPER = 4'd13, TRAP = 4'd14;

  localparam logic [31:0] I_ADD   = 32'h002081B3, I_ADDI  = 32'h00108093;
  localparam logic [31:0] I_LW    = 32'h0000A103, I_SW    = 32'h0020A023;
  localparam logic [31:0] I_BNE   = 32'h00209463, I_BGEU  = 32'h0020F463;
  localparam logic [31:0] I_JAL   = 32'h008000EF, I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_LUI   = 32'h123450B7, I_AUIPC = 32'h00000097;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  int          checks = 0, errors = 0;
  logic [21:0] sb[$];

  always #5 clk = ~clk;

  mc_control_unit_if ifc1 ();
  mc_control_unit_if ifc2 ();

  assign ifc1.instr = instr;
  assign ifc1.zero = zero;
  assign ifc1.lt = lt;
  assign ifc1.ltu = ltu;
  assign ifc1.mem_ready = mem_ready;
  assign ifc2.instr = instr;
  assign ifc2.zero = zero;
  assign ifc2.lt = lt;
  assign ifc2.ltu = ltu;
  assign ifc2.mem_ready = mem_ready;

  mc_control_unit dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc1.master)
  );

  mc_control_unit #(
    .MEM_HANDSHAKE   (1'b0),
    .ENABLE_JALR     (1'b0),
    .ENABLE_UPPER    (1'b0),
    .TRAP_ON_ILLEGAL (1'b0)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc2.master)
  );

  logic [21:0] out1, out2;
  assign out1 = {ifc1.state, ifc1.mem_req, ifc1.pc_write, ifc1.ir_write, ifc1.mem_write,
                 ifc1.reg_write, ifc1.adr_src, ifc1.alu_src_a, ifc1.alu_src_b, ifc1.alu_op,
                 ifc1.result_src, ifc1.imm_src, ifc1.illegal};
  assign out2 = {ifc2.state, ifc2.mem_req, ifc2.pc_write, ifc2.ir_write, ifc2.mem_write,
                 ifc2.reg_write, ifc2.adr_src, ifc2.alu_src_a, ifc2.alu_src_b, ifc2.alu_op,
                 ifc2.result_src, ifc2.imm_src, ifc2.illegal};

  // Expected output bundle, straight from the per-state output table.
  function automatic logic [21:0] exp_for(input bit sel, input logic [3:0] st,
                                          input logic [6:0] op, input logic rdy,
                                          input logic taken, input logic rst);
    logic mreq, pcw, irw, mw, rw, adr, ill, eff;
    logic [1:0] a, b, aop, rs;
    logic [2:0] imm;
    {mreq, pcw, irw, mw, rw, adr, ill} = '0;
    {a, b, aop, rs} = '0;
    eff = sel ? 1'b1 : rdy;
    case (op)
      7'b0100011:             imm = 3'b001;
      7'b1100011:             imm = 3'b010;
      7'b1101111:             imm = 3'b011;
      7'b0110111, 7'b0010111: imm = 3'b100;
      default:                imm = 3'b000;
    endcase
    case (st)
      FETCH:    begin mreq = 1; b = 2'b10; rs = 2'b10; pcw = eff; irw = eff; end
      DECODE:   begin a = 2'b01; b = 2'b01; end
      MEMADR:   begin a = 2'b10; b = 2'b01; end
      MEMREAD:  begin mreq = 1; adr = 1; end
      MEMWB:    begin rs = 2'b01; rw = 1; end
      MEMWRITE: begin mreq = 1; adr = 1; mw = 1; end
      EXEC_R:   begin a = 2'b10; aop = 2'b10; end
      EXEC_I:   begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      ALUWB:    rw = 1;
      BRANCH:   begin a = 2'b10; aop = 2'b01; pcw = taken; end
      JAL:      begin pcw = 1; a = 2'b01; b = 2'b10; end
      JALR:     begin a = 2'b10; b = 2'b01; rs = 2'b10; pcw = 1; end
      LINK:     begin a = 2'b01; b = 2'b10; end
      UPPER:    begin a = op[5] ? 2'b11 : 2'b01; b = 2'b01; end
      TRAP:     ill = 1;
      default:  ;
    endcase
    if (rst) {mreq, pcw, irw, mw, rw} = '0;
    return {st, mreq, pcw, irw, mw, rw, adr, a, b, aop, rs, imm, ill};
  endfunction

  // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
  task automatic cyc(input logic [3:0] st, input logic rdy = 1'b1, input logic z = 1'b0,
                     input logic l = 1'b0, input logic taken = 1'b0, input bit sel = 1'b0);
    logic [21:0] got, want;
    mem_ready = rdy;
    zero = z;
    lt = l;
    ltu = l;
    sb.push_back(exp_for(sel, st, instr[6:0], rdy, taken, reset));
    @(negedge clk);
    got = sel ? out2 : out1;
    want = sb.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL dut%0d step%0d st%0d instr=%h: got %h expected %h",
             sel ? 2 : 1, checks, st, instr, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic raw_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc(FETCH);  // reset still high: enables suppressed even with mem_ready
    reset = 1'b0;

    // Stripped instance: single-cycle fetch, illegal/JALR/LUI fall back to FETCH
    instr = I_ILL;
    cyc(FETCH, 1'b0, 0, 0, 0, 1);
    cyc(DECODE, 1'b1, 0, 0, 0, 1);
    instr = I_LUI;
    cyc(FETCH, 1'b0, 0, 0, 0, 1);
    cyc(DECODE, 1'b1, 0, 0, 0, 1);
    instr = I_JALR;
    cyc(FETCH, 1'b1, 0, 0, 0, 1);
    cyc(DECODE, 1'b1, 0, 0, 0, 1);
    cyc(FETCH, 1'b1, 0, 0, 0, 1);
    raw_reset();

    instr = I_ADD;
    cyc(FETCH); cyc(DECODE); cyc(EXEC_R); cyc(ALUWB);
    instr = I_ADDI;
    cyc(FETCH); cyc(DECODE); cyc(EXEC_I); cyc(ALUWB);
    instr = I_LW;
    cyc(FETCH); cyc(DECODE); cyc(MEMADR);
    cyc(MEMREAD, 1'b0); cyc(MEMREAD, 1'b0); cyc(MEMREAD, 1'b1); cyc(MEMWB);
    instr = I_SW;
    cyc(FETCH, 1'b0); cyc(FETCH, 1'b1); cyc(DECODE); cyc(MEMADR);
    cyc(MEMWRITE, 1'b0); cyc(MEMWRITE, 1'b1);
    instr = I_BNE;
    cyc(FETCH); cyc(DECODE); cyc(BRANCH, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(FETCH); cyc(DECODE, 1'b1, 1'b1); cyc(BRANCH, 1'b1, 1'b1, 1'b0, 1'b0);
    instr = I_BGEU;
    cyc(FETCH); cyc(DECODE); cyc(BRANCH, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(FETCH); cyc(DECODE); cyc(BRANCH, 1'b1, 1'b0, 1'b1, 1'b0);
    instr = I_JAL;
    cyc(FETCH); cyc(DECODE); cyc(JAL); cyc(ALUWB);
    instr = I_JALR;
    cyc(FETCH); cyc(DECODE); cyc(JALR); cyc(LINK); cyc(ALUWB);
    instr = I_LUI;
    cyc(FETCH); cyc(DECODE); cyc(UPPER); cyc(ALUWB);
    instr = I_AUIPC;
    cyc(FETCH); cyc(DECODE); cyc(UPPER); cyc(ALUWB);

    // Reset held three cycles while a store waits for memory
    instr = I_SW;
    cyc(FETCH); cyc(DECODE); cyc(MEMADR); cyc(MEMWRITE, 1'b0);
    reset = 1'b1;
    cyc(MEMWRITE, 1'b0); cyc(FETCH, 1'b0); cyc(FETCH, 1'b1);
    reset = 1'b0;
    cyc(FETCH); cyc(DECODE); cyc(MEMADR); cyc(MEMWRITE, 1'b1);

    // Illegal opcode traps and stays until reset
    instr = I_ILL;
    cyc(FETCH); cyc(DECODE); cyc(TRAP); cyc(TRAP, 1'b1, 1'b1); cyc(TRAP, 1'b0);
    reset = 1'b1;
    cyc(TRAP); cyc(FETCH);
    reset = 1'b0;
    cyc(FETCH, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
